adc_conditioner: RTL
====================

Name: adc_conditioner

Overview:
- Sits between the ADCstream DDR demux output (8-bit offset-binary channel A samples) and AMdemod.
- Converts each sample to 16-bit two's complement and removes DC offset with a leaky integrator.
- Applies a power-of-two AGC gain with saturation, and emits valid-qualified samples in the 16-bit signed format AMdemod consumes.

Parameters:
- IN_W, 8, ADC sample width (offset binary).
- OUT_W, 16, output sample width (signed).
- DC_SHIFT, 10, leaky-integrator time constant as log2 of samples.
- WIN_LOG2, 12, AGC measurement window as log2 of valid samples.
- TARGET_PEAK, 16384, upper AGC peak threshold. Lower threshold is TARGET_PEAK/2.
- MAX_SHIFT, 7, maximum gain left-shift.
- INIT_SHIFT, 0, gain shift after reset. Also the fixed shift when AGC is compiled out.

Ports:
- clk  in  1  system clock (ADC clock domain).
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data qualifier.
- in_data  in  IN_W  offset-binary ADC sample.
- agc_freeze  in  1  when 1, holds gain_shift.
- out_valid  out  1  out_data qualifier.
- out_data  out  OUT_W  signed conditioned sample.
- out_clip  out  1  high with out_valid when this sample saturated.
- gain_shift  out  3  current AGC shift.
- dc_est  out  OUT_W  current signed DC estimate.

Behaviour:
- Reset is synchronous and active-high. One clock only.
- Reset values:
  - out_valid=0, out_data=0, out_clip=0.
  - gain_shift=INIT_SHIFT, dc_est=0, integrator accumulator=0.
  - FSM=MEASURE, window counter=0, peak=0, settle counter=0.
- Reset mid-operation clears everything above on the next edge; in-flight samples are discarded.
- Pipeline: three registered stages with per-stage valid bits. It advances every clock; bubbles propagate. Latency is exactly 3 clocks from in_valid to out_valid.
  - S1: s = {~in_data[IN_W-1], in_data[IN_W-2:0]} << (OUT_W-IN_W), as signed OUT_W. Example: 0x80 maps to 0, 0x00 to -32768, 0xFF to 0x7F00.
  - S2: d = s - dc_est, computed at OUT_W+1 bits. On a valid S2 sample only:
    - acc(OUT_W+DC_SHIFT+1 bits) += sign-extended d;
    - dc_est = acc >>> DC_SHIFT, registered.
  - S3: g = d <<< gain_shift, computed at OUT_W+MAX_SHIFT+1 bits, then saturated to [-32768, 32767]. out_clip=1 when saturation occurred.
- AGC FSM states: MEASURE, UPDATE, SETTLE.
  - MEASURE:
    - On each out_valid, peak = max(peak, |out_data|). |-32768| is taken as 32767.
    - The window counter increments on each out_valid.
    - When the counter reaches 2^WIN_LOG2-1 on an out_valid, go to UPDATE.
  - UPDATE (one clock):
    - If agc_freeze=1, hold gain_shift.
    - Else if peak > TARGET_PEAK and gain_shift > 0, decrement gain_shift.
    - Else if peak < TARGET_PEAK/2 and gain_shift < MAX_SHIFT, increment gain_shift.
    - Otherwise hold gain_shift.
    - Clear peak and the window counter, then go to SETTLE.
  - SETTLE: discard 3 valid outputs (pipeline flush, not counted toward the window), then go to MEASURE.
- The new gain_shift applies to the first sample entering S3 after the UPDATE clock.
- gain_shift saturates at 0 and at MAX_SHIFT and never wraps.
- The window counter wraps to 0 only via UPDATE.
- in_valid gaps: window length is counted in valid samples, not clocks.

Optional Feature:
- ADC_COND_AGC_EN defined: AGC FSM, peak detector and window counter are present, as described above.
- Not defined: no FSM logic. gain_shift is the constant INIT_SHIFT, agc_freeze is ignored, and S3 saturation and out_clip remain.

Decomposition:
- Package adc_cond_pkg holds:
  - the agc_state_t enum {MEASURE, UPDATE, SETTLE};
  - the constants SETTLE_CNT=3 and PIPE_LAT=3;
  - the saturation limit constants SAT_MAX and SAT_MIN.
- Sub-module dc_blocker: the S2 leaky integrator. Ports: clk, rst, valid, d in, dc_est out.

Test Plan:
- Reset: hold rst 2 clocks with in_valid=1, in_data=0xFF -> out_valid=0, out_data=0, gain_shift=INIT_SHIFT, dc_est=0 throughout; first out_valid appears 3 clocks after rst deasserts.
- Conversion/latency: first sample after reset is in_data=0xC0 -> out_data=0x4000 exactly 3 clocks later, out_clip=0.
- DC convergence: constant 0x90 for 8*2^DC_SHIFT samples -> dc_est within 0x1000±16, and |out_data| ≤ 16.
- AGC up: square wave alternating 0x88/0x78 (±2048) with INIT_SHIFT=0 -> gain_shift goes 1 then 2 after successive windows, then holds at 2; out_data settles to ±8192.
- AGC down/clip: INIT_SHIFT=3, square wave 0xFF/0x00 -> out_data is 32767/-32768 with out_clip pulses; gain_shift decrements once per window to 0; out_clip stops once unsaturated.
- Freeze and gaps: agc_freeze=1 and in_valid toggling every other clock -> gain_shift is constant across 3 windows, and UPDATE fires every 2*(2^WIN_LOG2+3) clocks.

Source files
------------

// File: rtl/adc_cond_pkg.sv
// adc_cond_pkg: shared types and constants for the ADC conditioning path.
//   agc_state_t      - AGC controller states (MEASURE, UPDATE, SETTLE)
//   SETTLE_CNT       - valid outputs ignored by the AGC after a gain change
//   PIPE_LAT         - clocks from in_valid to out_valid
//   SAT_MAX/SAT_MIN  - saturation limits of the 16-bit signed output
package adc_cond_pkg;

    typedef enum logic [1:0] {
        MEASURE,
        UPDATE,
        SETTLE
    } agc_state_t;

    localparam int unsigned SETTLE_CNT = 3;
    localparam int unsigned PIPE_LAT   = 3;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

endpackage

// File: rtl/adc_conditioner_dc_blocker.sv
// dc_blocker: leaky-integrator DC estimator for the S2 stage.
//   clk, rst  - clock, synchronous active-high reset
//   valid     - d carries a real sample this clock
//   d         - signed sample minus current estimate (OUT_W+1 bits)
//   dc_est    - registered DC estimate, acc >>> DC_SHIFT
module dc_blocker
    import adc_cond_pkg::*;
#(
    parameter int OUT_W    = 16,
    parameter int DC_SHIFT = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic signed [OUT_W:0]   d,
    output logic signed [OUT_W-1:0] dc_est
);

    localparam int ACC_W = OUT_W + DC_SHIFT + 1;

    logic signed [ACC_W-1:0] acc;
    logic        [ACC_W-1:0] acc_nx;

    assign acc_nx = acc + {{DC_SHIFT{d[OUT_W]}}, d};

    // The estimate is taken from the updated accumulator so the next
    // sample in S2 already sees this sample's contribution.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            dc_est <= '0;
        end else if (valid) begin
            acc    <= acc_nx;
            dc_est <= acc_nx[DC_SHIFT +: OUT_W];
        end
    end

endmodule

// File: rtl/adc_conditioner.sv
// adc_conditioner: offset-binary ADC samples -> DC-free, gain-scaled,
// saturated 16-bit signed samples for AMdemod. Three-stage pipeline:
//   S1 offset-binary to two's complement, S2 DC removal, S3 gain + saturate.
// Build option: define ADC_COND_AGC_EN for the AGC controller (peak
// detector, window counter, MEASURE/UPDATE/SETTLE FSM). Without it the
// gain is fixed at INIT_SHIFT and agc_freeze is ignored.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   in_valid    - in_data qualifier
//   in_data     - offset-binary ADC sample
//   agc_freeze  - hold gain_shift at window updates
//   out_valid   - out_data qualifier
//   out_data    - conditioned signed sample
//   out_clip    - this output sample saturated
//   gain_shift  - current gain left-shift
//   dc_est      - current DC estimate
module adc_conditioner #(
    parameter int IN_W        = 8,
    parameter int OUT_W       = 16,
    parameter int DC_SHIFT    = 10,
    parameter int WIN_LOG2    = 12,
    parameter int TARGET_PEAK = 16384,
    parameter int MAX_SHIFT   = 7,
    parameter int INIT_SHIFT  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [IN_W-1:0]         in_data,
    input  logic                    agc_freeze,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_clip,
    output logic [2:0]              gain_shift,
    output logic signed [OUT_W-1:0] dc_est
);

    import adc_cond_pkg::*;

    localparam int G_W  = OUT_W + MAX_SHIFT + 1;
    localparam int PK_W = OUT_W - 1;
    localparam logic signed [G_W-1:0] G_MAX = G_W'(SAT_MAX);
    localparam logic signed [G_W-1:0] G_MIN = G_W'(SAT_MIN);

    logic                    s1_valid;
    logic signed [OUT_W-1:0] s1_data;
    logic                    s2_valid;
    logic signed [OUT_W:0]   s2_d;
    logic signed [OUT_W:0]   d_calc;
    logic signed [G_W-1:0]   g;
    logic                    g_hi;
    logic                    g_lo;

    // S1: flip the MSB and left-justify.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_data  <= {~in_data[IN_W-1], in_data[IN_W-2:0], {(OUT_W-IN_W){1'b0}}};
        end
    end

    // S2: subtract the running DC estimate at one extra bit of headroom.
    assign d_calc = {s1_data[OUT_W-1], s1_data} - {dc_est[OUT_W-1], dc_est};

    dc_blocker #(
        .OUT_W    (OUT_W),
        .DC_SHIFT (DC_SHIFT)
    ) u_dc_blocker (
        .clk    (clk),
        .rst    (rst),
        .valid  (s1_valid),
        .d      (d_calc),
        .dc_est (dc_est)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_d     <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_d     <= d_calc;
        end
    end

    // S3: widen so the largest shift cannot overflow, then saturate.
    assign g    = {{MAX_SHIFT{s2_d[OUT_W]}}, s2_d} <<< gain_shift;
    assign g_hi = g > G_MAX;
    assign g_lo = g < G_MIN;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_clip  <= 1'b0;
        end else begin
            out_valid <= s2_valid;
            out_clip  <= s2_valid & (g_hi | g_lo);
            if (g_hi) begin
                out_data <= OUT_W'(SAT_MAX);
            end else if (g_lo) begin
                out_data <= OUT_W'(SAT_MIN);
            end else begin
                out_data <= g[OUT_W-1:0];
            end
        end
    end

`ifdef ADC_COND_AGC_EN
    localparam logic [PK_W-1:0] TGT_HI = PK_W'(TARGET_PEAK);
    localparam logic [PK_W-1:0] TGT_LO = PK_W'(TARGET_PEAK / 2);

    agc_state_t          state, state_nx;
    logic [WIN_LOG2-1:0] win_cnt, win_cnt_nx;
    logic [PK_W-1:0]     peak, peak_nx, mag;
    logic [1:0]          settle_cnt, settle_cnt_nx;
    logic [2:0]          gain_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MEASURE;
            win_cnt    <= '0;
            peak       <= '0;
            settle_cnt <= '0;
            gain_shift <= 3'(INIT_SHIFT);
        end else begin
            state      <= state_nx;
            win_cnt    <= win_cnt_nx;
            peak       <= peak_nx;
            settle_cnt <= settle_cnt_nx;
            gain_shift <= gain_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        win_cnt_nx    = win_cnt;
        peak_nx       = peak;
        settle_cnt_nx = settle_cnt;
        gain_nx       = gain_shift;
        mag           = PK_W'(out_data);

        // |SAT_MIN| does not fit in PK_W bits; clamp it to full scale.
        if (out_data[OUT_W-1]) begin
            mag = (out_data == OUT_W'(SAT_MIN)) ? '1 : PK_W'(-out_data);
        end

        unique case (state)
            MEASURE: begin
                if (out_valid) begin
                    if (mag > peak) begin
                        peak_nx = mag;
                    end
                    if (win_cnt == '1) begin
                        state_nx = UPDATE;
                    end else begin
                        win_cnt_nx = win_cnt + 1'b1;
                    end
                end
            end
            UPDATE: begin
                if (!agc_freeze) begin
                    if (peak > TGT_HI && gain_shift != 3'd0) begin
                        gain_nx = gain_shift - 3'd1;
                    end else if (peak < TGT_LO && gain_shift < 3'(MAX_SHIFT)) begin
                        gain_nx = gain_shift + 3'd1;
                    end
                end
                peak_nx       = '0;
                win_cnt_nx    = '0;
                settle_cnt_nx = '0;
                state_nx      = SETTLE;
            end
            SETTLE: begin
                if (out_valid) begin
                    if (settle_cnt == 2'(SETTLE_CNT - 1)) begin
                        state_nx = MEASURE;
                    end else begin
                        settle_cnt_nx = settle_cnt + 2'd1;
                    end
                end
            end
            default: state_nx = MEASURE;
        endcase
    end
`else
    logic unused_freeze;
    assign unused_freeze = agc_freeze;
    assign gain_shift    = 3'(INIT_SHIFT);
`endif

endmodule
